// File: rtl/ln_range_reduce_seq_pkg.sv
// Shared types and IEEE-754-style field classifiers for the ln range reducer.
// Classifiers take zero-extended exponent/mantissa fields plus the exponent width.
package ln_rr_pkg;

  localparam int FLD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LN_RR_OK     = 2'd0,
    LN_RR_DOMAIN = 2'd1,
    LN_RR_LIMIT  = 2'd2,
    LN_RR_INF    = 2'd3
  } status_e;

  function automatic logic [FLD_W-1:0] exp_ones(input int exp_w);
    return (FLD_W'(1) << exp_w) - FLD_W'(1);
  endfunction

  function automatic logic is_zero(input logic [FLD_W-1:0] exp_f, input logic [FLD_W-1:0] man_f);
    return (exp_f == '0) && (man_f == '0);
  endfunction

  function automatic logic is_subnormal(input logic [FLD_W-1:0] exp_f, input logic [FLD_W-1:0] man_f);
    return (exp_f == '0) && (man_f != '0);
  endfunction

  function automatic logic is_inf(input logic [FLD_W-1:0] exp_f, input logic [FLD_W-1:0] man_f,
                                  input int exp_w);
    return (exp_f == exp_ones(exp_w)) && (man_f == '0);
  endfunction

  function automatic logic is_nan(input logic [FLD_W-1:0] exp_f, input logic [FLD_W-1:0] man_f,
                                  input int exp_w);
    return (exp_f == exp_ones(exp_w)) && (man_f != '0);
  endfunction

endpackage

// File: rtl/ln_range_reduce_seq_sint_to_fp.sv
// Combinational signed-integer to float converter (leading-one detect + shift).
// Exact as long as IN_W <= MAN_W+1; zero input yields +0.0.
module sint_to_fp #(
  parameter int IN_W  = 6,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [IN_W-1:0]        in_int,
  output logic [EXP_W+MAN_W:0]   out_fp
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int PW   = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic              sgn;
  logic [IN_W-1:0]   mag;
  logic [PW-1:0]     lead;
  logic [MAN_W-1:0]  man;

  always_comb begin
    sgn  = in_int[IN_W-1];
    mag  = sgn ? (~in_int + IN_W'(1)) : in_int;
    lead = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag[i]) lead = PW'(i);
    end
    // Leading one lands on bit MAN_W and is dropped as the hidden bit.
    man = MAN_W'({mag, {MAN_W{1'b0}}} >> lead);
    if (mag == '0) begin
      out_fp = '0;
    end else begin
      out_fp = {sgn, EXP_W'(BIAS) + EXP_W'(lead), man};
    end
  end

endmodule

// File: rtl/ln_range_reduce_seq.sv
// Sequential range reducer a = 2^n * x, x in [1,2); latency 3+|e-BIAS| (capped 3+MAX_STEPS), specials 1.
// Result held in DONE until out_ready; in_ready only in IDLE. LN_RR_ONE_NUDGE_EN turns x==1.0 into 1.0+1ulp.
module ln_range_reduce_seq
  import ln_rr_pkg::*;
#(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int MAX_STEPS = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_n,
  output logic [EXP_W+MAN_W:0] out_x,
  output logic [1:0]           out_status
);

  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int CNT_W = $clog2(MAX_STEPS+1) + 1;

  localparam logic [EXP_W-1:0]        BIAS_E  = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0]        EXP_ONE = 1;
  localparam logic signed [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(MAX_STEPS);

  state_e                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic [EXP_W-1:0]         exp_q, exp_d;
  logic [MAN_W-1:0]         man_q, man_d;
  logic signed [CNT_W-1:0]  count_q, count_d;
  logic                     limit_q, limit_d;
  logic [FP_W-1:0]          out_n_q, out_n_d;
  logic [FP_W-1:0]          out_x_q, out_x_d;
  status_e                  status_q, status_d;

  logic                     in_sign;
  logic [EXP_W-1:0]         in_exp;
  logic [MAN_W-1:0]         in_man;
  logic                     in_domain, in_inf;
  logic [CNT_W-1:0]         count_abs;
  logic [FP_W-1:0]          n_fp;
  logic [FP_W-1:0]          x_fin;

  assign in_sign = in_data[EXP_W+MAN_W];
  assign in_exp  = in_data[EXP_W+MAN_W-1:MAN_W];
  assign in_man  = in_data[MAN_W-1:0];

  // Negative operands (including -inf) are a domain error, checked before infinity.
  assign in_domain = in_sign
                   || is_zero(FLD_W'(in_exp), FLD_W'(in_man))
                   || is_subnormal(FLD_W'(in_exp), FLD_W'(in_man))
                   || is_nan(FLD_W'(in_exp), FLD_W'(in_man), EXP_W);
  assign in_inf    = is_inf(FLD_W'(in_exp), FLD_W'(in_man), EXP_W);

  assign count_abs = count_q[CNT_W-1] ? (~$unsigned(count_q) + CNT_W'(1)) : $unsigned(count_q);

  sint_to_fp #(
    .IN_W  (CNT_W),
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_n_to_fp (
    .in_int (count_q),
    .out_fp (n_fp)
  );

  assign in_ready   = (state_q == IDLE) && !reset;
  assign out_valid  = (state_q == DONE);
  assign out_n      = out_n_q;
  assign out_x      = out_x_q;
  assign out_status = status_q;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_d    = man_q;
    count_d  = count_q;
    limit_d  = limit_q;
    out_n_d  = out_n_q;
    out_x_d  = out_x_q;
    status_d = status_q;

    x_fin = {sign_q, exp_q, man_q};
`ifdef LN_RR_ONE_NUDGE_EN
    if (!limit_q && (exp_q == BIAS_E) && (man_q == '0)) x_fin[0] = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          man_d   = in_man;
          count_d = '0;
          limit_d = 1'b0;
          if (in_domain) begin
            state_d  = DONE;
            out_n_d  = '0;
            out_x_d  = '0;
            status_d = LN_RR_DOMAIN;
          end else if (in_inf) begin
            state_d  = DONE;
            out_n_d  = '0;
            out_x_d  = '0;
            status_d = LN_RR_INF;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (exp_q == BIAS_E) begin
          state_d = CONV;
        end else if (count_abs == CNT_MAX) begin
          state_d = CONV;
          limit_d = 1'b1;
        end else if (exp_q > BIAS_E) begin
          exp_d   = exp_q - EXP_ONE;
          count_d = count_q + CNT_ONE;
        end else begin
          exp_d   = exp_q + EXP_ONE;
          count_d = count_q - CNT_ONE;
        end
      end
      CONV: begin
        out_n_d = n_fp;
        out_x_d = x_fin;
        if (limit_q) status_d = LN_RR_LIMIT;
        else         status_d = LN_RR_OK;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      count_q  <= '0;
      limit_q  <= 1'b0;
      out_n_q  <= '0;
      out_x_q  <= '0;
      status_q <= LN_RR_OK;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      out_n_q  <= out_n_d;
      out_x_q  <= out_x_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_ln_range_reduce_seq.sv
// Self-checking bench for ln_range_reduce_seq (single precision); expected results queued at drive time.
module tb_ln_range_reduce_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_n;
  logic [31:0] out_x;
  logic [1:0]  out_status;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] n;
    logic [31:0] x;
    logic [1:0]  st;
    int          lat;
  } exp_t;

  exp_t sb[$];

`ifdef LN_RR_ONE_NUDGE_EN
  localparam logic [31:0] ONE_X = 32'h3F800001;
`else
  localparam logic [31:0] ONE_X = 32'h3F800000;
`endif

  ln_range_reduce_seq #(
    .EXP_W     (8),
    .MAN_W     (23),
    .MAX_STEPS (30)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_n      (out_n),
    .out_x      (out_x),
    .out_status (out_status)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] en, input logic [31:0] ex,
                       input logic [1:0] es, input int elat, input int hold, input string tag);
    exp_t e;
    int w;
    int lat;
    logic [31:0] hn, hx;
    logic [1:0] hs;
    logic stable, rdy_low;
    e.n = en; e.x = ex; e.st = es; e.lat = elat;
    sb.push_back(e);

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = a;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s accept: in_ready=%b required 1", tag, in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;

    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat) $display("FAIL %s latency: got %0d required %0d", tag, lat, e.lat);
    else n_pass++;
    n_checks++;
    if (out_n !== e.n) $display("FAIL %s out_n: got %h required %h", tag, out_n, e.n);
    else n_pass++;
    n_checks++;
    if (out_x !== e.x) $display("FAIL %s out_x: got %h required %h", tag, out_x, e.x);
    else n_pass++;
    n_checks++;
    if (out_status !== e.st) $display("FAIL %s out_status: got %0d required %0d", tag, out_status, e.st);
    else n_pass++;

    if (hold > 0) begin
      hn = out_n; hx = out_x; hs = out_status;
      stable = 1'b1; rdy_low = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_n !== hn || out_x !== hx || out_status !== hs) stable = 1'b0;
        if (in_ready !== 1'b0) rdy_low = 1'b0;
      end
      n_checks++;
      if (stable !== 1'b1) $display("FAIL %s hold_stable: outputs changed, got %b required 1", tag, stable);
      else n_pass++;
      n_checks++;
      if (rdy_low !== 1'b1) $display("FAIL %s hold_in_ready: in_ready seen high, got %b required 1", tag, rdy_low);
      else n_pass++;
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL %s release_valid: out_valid=%b required 0", tag, out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s release_ready: in_ready=%b required 1", tag, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_n !== 32'h0) $display("FAIL reset out_n: got %h required 0", out_n);
    else n_pass++;
    n_checks++;
    if (out_x !== 32'h0) $display("FAIL reset out_x: got %h required 0", out_x);
    else n_pass++;
    n_checks++;
    if (out_status !== 2'd0) $display("FAIL reset out_status: got %0d required 0", out_status);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_reduce();
    do_op(32'h41000000, 32'h40400000, ONE_X,        2'd0, 6, 0, "eight");
    do_op(32'h3EC00000, 32'hC0000000, 32'h3FC00000, 2'd0, 5, 0, "three_eighths");
    do_op(32'h3F800000, 32'h00000000, ONE_X,        2'd0, 3, 0, "one");
    do_op(32'h40400000, 32'h3F800000, 32'h3FC00000, 2'd0, 4, 0, "three");
  endtask

  task automatic test_special();
    do_op(32'hBF800000, 32'h0, 32'h0, 2'd1, 1, 0, "minus_one");
    do_op(32'h7F800000, 32'h0, 32'h0, 2'd3, 1, 0, "plus_inf");
    do_op(32'hFF800000, 32'h0, 32'h0, 2'd1, 1, 0, "minus_inf");
    do_op(32'h00000000, 32'h0, 32'h0, 2'd1, 1, 0, "zero");
    do_op(32'h80000000, 32'h0, 32'h0, 2'd1, 1, 0, "neg_zero");
    do_op(32'h7FC00000, 32'h0, 32'h0, 2'd1, 1, 0, "nan");
    do_op(32'h00000001, 32'h0, 32'h0, 2'd1, 1, 0, "subnormal");
  endtask

  task automatic test_limit();
    do_op(32'h53800000, 32'h41F00000, 32'h44800000, 2'd2, 33, 0, "two_pow_40");
    do_op(32'h30800000, 32'hC1F00000, ONE_X,        2'd0, 33, 0, "two_pow_m30");
    do_op(32'h30000000, 32'hC1F00000, 32'h3F000000, 2'd2, 33, 0, "two_pow_m31");
  endtask

  task automatic test_backpressure();
    do_op(32'h41000000, 32'h40400000, ONE_X, 2'd0, 6, 5, "bp_eight");
    do_op(32'h3EC00000, 32'hC0000000, 32'h3FC00000, 2'd0, 5, 0, "bp_follow");
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h49800000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort out_valid: rose=%b required 0", seen);
    else n_pass++;
    n_checks++;
    if ({out_n, out_x, out_status} !== 66'h0)
      $display("FAIL abort outputs: n=%h x=%h st=%0d required all 0", out_n, out_x, out_status);
    else n_pass++;
    do_op(32'h40800000, 32'h40000000, ONE_X, 2'd0, 5, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [4] = '{32'h41000000, 32'hBF800000, 32'h3EC00000, 32'h7F800000};
    logic [31:0] tn [4] = '{32'h40400000, 32'h0,        32'hC0000000, 32'h0};
    logic [31:0] tx [4] = '{ONE_X,        32'h0,        32'h3FC00000, 32'h0};
    logic [1:0]  ts [4] = '{2'd0,         2'd1,         2'd0,         2'd3};
    int          tl [4] = '{6,            1,            5,            1};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tn[i], tx[i], ts[i], tl[i], 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_reduce();
    test_special();
    test_limit();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ln_range_reduce_seq.md
Name: ln_range_reduce_seq

Overview:
Sequential, parametrised range reducer for the ln unit. It takes one IEEE-754-style float and scales it by powers of two, one step per cycle, until the mantissa-carrying value x lies in [1,2). It returns x and the step count n as a float, so that ln(a) = n*ln2 + ln(x). It differs from the combinational version as follows: it handles inputs below 1 by doubling, giving a negative n; it uses a valid/ready handshake; it has parametrised float width and step limit; and it reports a status code. It sits between the operand mux and the ln series evaluator.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width
MAX_STEPS, 30, maximum number of scaling steps before saturation; must be < 2^(MAN_W+1)
(derived) FP_W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; CNT_W = clog2(MAX_STEPS+1)+1, signed

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand valid
in_ready  out  1  high only in IDLE
in_data  in  FP_W  operand a
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  downstream accepts
out_n  out  FP_W  signed step count as float (+0.0 when zero)
out_x  out  FP_W  reduced value
out_status  out  2  0 ok, 1 domain error (a<=0, NaN, subnormal), 2 step limit hit, 3 infinity

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. Reset forces state IDLE, out_valid=0, out_n=0, out_x=0, out_status=0 and count=0. in_ready=1 once reset deasserts.
- State IDLE: in_ready=1. On in_valid&&in_ready, the operand is registered and classified.
  - Sign=1, zero, subnormal or NaN: go to DONE with status 1, out_n=0, out_x=0.
  - Infinity: go to DONE with status 3, same zero outputs.
  - Otherwise: go to RUN with count=0.
- State RUN, one cycle per step:
  - If exp==BIAS: go to CONV.
  - Else if |count|==MAX_STEPS: go to CONV with the sticky limit flag set.
  - Else if exp>BIAS: exp-=1, count+=1.
  - Else: exp+=1, count-=1.
  - Mantissa and sign are never modified.
- State CONV: one cycle. count is converted to float (exact, round not needed) and out_n, out_x and out_status are registered. Then go to DONE.
- State DONE: out_valid=1. Outputs are stable while out_ready=0. On out_ready, out_valid drops the same edge and the state returns to IDLE. A new operand cannot be accepted in the same cycle as the handoff, so there is no overlap.
- Latency: acceptance edge to out_valid rising is 3+|e-BIAS| cycles, capped at 3+MAX_STEPS. Special-case inputs take 1 cycle.
- Reset mid-RUN or mid-DONE aborts silently and drops the operand. No output is produced.
- in_valid while not in IDLE is ignored. Upstream must hold the operand.

Optional Feature:
Macro LN_RR_ONE_NUDGE_EN.
- Defined: if the final x equals exactly 1.0 (exp==BIAS, mantissa==0) with status 0, out_x is replaced by 1.0+1ulp (mantissa LSB=1). This protects downstream series that divide by ln(x) or by (x-1).
- Undefined: out_x=1.0 is passed through unchanged.

Decomposition:
- Package ln_rr_pkg holds:
  - the state enum (IDLE, RUN, CONV, DONE)
  - the status codes (LN_RR_OK, LN_RR_DOMAIN, LN_RR_LIMIT, LN_RR_INF)
  - classify functions (is_zero, is_inf, is_nan, is_subnormal) parametrised via the function arguments
- One sub-module, sint_to_fp: a combinational signed-integer-to-float converter (leading-one detect plus shift). It is instantiated once in CONV and is reusable by the exp unit.

Test Plan:
- 8.0 (0x41000000) -> n=3.0 (0x40400000). x=0x3F800001 with nudge, 0x3F800000 without. Status 0. out_valid 6 cycles after acceptance.
- 0.375 (0x3EC00000) -> n=-2.0 (0xC0000000), x=1.5 (0x3FC00000), status 0, latency 5.
- 1.0 (0x3F800000) -> n=+0.0 (0x00000000), x per nudge rule, latency 3. Also -1.0 (0xBF800000) -> status 1, n=x=0, latency 1.
- 2^40 (0x53800000) -> status 2, n=30.0 (0x41F00000), x=2^10 (0x44800000), latency 33. +inf (0x7F800000) -> status 3.
- Backpressure: out_ready low for 5 cycles in DONE -> out_* stable and in_ready=0 throughout. On release, IDLE follows next cycle and a new operand is accepted.
- Assert reset for 1 cycle in the middle of RUN on 2^20 -> out_valid never rises for that operand, all outputs 0, next operand 4.0 gives n=2.0 (0x40000000).
